lcd_responder: RTL and testbench
================================

# lcd_responder

Synthesizable HD44780-style character-LCD responder that sits on the receiving end of the top-level `lcd_data`/`lcd_ctrl`/`lcd_enable` bus. It latches bus transactions, executes the instruction subset the CPU firmware uses, and maintains an 80-byte DDRAM shadow with address counter, busy flag and error flags. The block is instantiated beside `top` in system benches and in the FPGA debug build, and exposes a debug read port so the displayed text can be checked.

## Interface

- `CMD_CYCLES`, default 4: busy duration in `clk` cycles after any accepted non-clear transaction (≥1).
- `clk`, input, 1: system clock, same domain as the LCD bus driver.
- `rst_n`, input, 1: reset, asynchronous, active-high.
- `lcd_data`, input, 8: instruction or data byte.
- `lcd_ctrl`, input, 2: bit0 = RS (0 instr/status, 1 data); bit1 = RW (0 write, 1 read).
- `lcd_enable`, input, 1: transaction strobe; latched on its falling edge.
- `rd_data`, output, 8: read response, valid while `lcd_enable` is high during a read.
- `busy`, output, 1: busy flag.
- `ac`, output, 7: DDRAM address counter.
- `display_on`, output, 1: display-control D bit.
- `entry_inc`, output, 1: entry-mode I/D bit (1 = increment).
- `cmd_strobe`, output, 1: one-cycle pulse per accepted write.
- `err`, output, 2: sticky; bit0 = write while busy, bit1 = illegal DDRAM address or unsupported instruction.
- `dbg_addr`, input, 7: DDRAM address for debug read.
- `dbg_char`, output, 8: combinational DDRAM content at `dbg_addr` (0x00 if address illegal).

## Operation

- Registers `en_q`, `data_q`, `ctrl_q` sample the bus every cycle. Falling edge = `en_q==1 && lcd_enable==0`; the transaction uses `data_q`/`ctrl_q`. Rising edge = `en_q==0 && lcd_enable==1`.
- DDRAM map: 0x00–0x27 → index 0–39 (line 0); 0x40–0x67 → index 40–79 (line 1); other addresses illegal.
- FSM states: CLEARING (fill index `clr_idx` with 0x20, one per cycle, 0→79), BUSY (down-counter), IDLE.
- Writes (RW=0) on falling edge, only in IDLE; in BUSY/CLEARING, ignored and `err[0]` set.
  - RS=1: DDRAM[ac] ← byte; ac advances.
  - 0x01 clear: ac←0, entry_inc←1, enter CLEARING.
  - 0x02/0x03 home: ac←0.
  - 0x04–0x07: entry_inc ← bit1.
  - 0x08–0x0F: display_on ← bit2.
  - 0x20–0x3F function set: accepted, no state.
  - 0x80|a: a legal → ac←a; a illegal → ac unchanged, `err[1]` set.
  - 0x00, 0x10–0x1F, 0x40–0x7F: no effect, `err[1]` set.
  - Every accepted write pulses `cmd_strobe`. Every accepted write except clear enters BUSY with count `CMD_CYCLES`.
- ac advance: increment wraps 0x27→0x40 and 0x67→0x00. Decrement wraps 0x00→0x67 and 0x40→0x27.
- Reads (RW=1) are allowed in any state and never set errors.
  - On rising edge, `rd_data` ← {busy, ac} (RS=0) or DDRAM[ac] (RS=1), held until the next rising edge.
  - On the falling edge of an RS=1 read, ac advances.
- Reset: ac=0, entry_inc=1, display_on=0, err=0, cmd_strobe=0, rd_data=0, busy=1, state CLEARING with clr_idx=0. The DDRAM itself is not reset; it is filled by the clear sequence.

## Timing

- The falling edge is detected at posedge P, which is the first posedge with `lcd_enable` low. DDRAM, ac, flags and state update at P. `cmd_strobe` and `busy` are high in the cycle after P.
- BUSY: `busy` stays high for exactly `CMD_CYCLES` cycles after P. A write whose falling edge is detected on the cycle `busy` reads 0 is accepted.
- CLEARING: exactly 80 cycles; `busy` is high throughout. Index 79 is written on the last cycle, then the FSM returns to IDLE.
- After reset deassertion, `busy` falls 80 cycles later.
- Reset asserted mid-clear or mid-busy: restart the CLEARING sequence from index 0.
- If an RS=1 read and a write would both modify ac in the same cycle, the write wins. Both cannot happen on one bus, so this case only arises from bench stimulus.
- `dbg_char` is combinational, with zero latency from `dbg_addr`.

## Test plan

- Reset, release, wait 80 cycles: `busy` falls at cycle 80; `dbg_char` = 0x20 at 0x00, 0x27, 0x40, 0x67; `ac`=0.
- Write 0x80|0x26, then data 'A', 'B', 'C' with gaps ≥ `CMD_CYCLES`: chars land at 0x26, 0x27, 0x40; `ac`=0x41; three `cmd_strobe` pulses.
- Send 0x04, 0x80 (ac=0), then data 'Z': 'Z' lands at 0x00; `ac`=0x67.
- Write data 1 cycle after the previous write (busy): byte ignored, `err[0]`=1, `ac` unchanged. Send 0xA8 (illegal address): `err[1]`=1, `ac` unchanged.
- Status read during BUSY after a data write to 0x05: `rd_data`=0x86. An RS=1 read at 0x05 returns the written byte; `ac`→0x06.
- Send clear 0x01, then assert reset at clear cycle 30: `busy` stays high 80 cycles after release; all 80 entries read 0x20.

Source files
------------

// File: rtl/lcd_responder.sv
// HD44780-style character-LCD responder: latches lcd_* bus strobes, executes the
// firmware's instruction subset and keeps an 80-byte DDRAM shadow with a debug read port.
`timescale 1ns/1ps
module lcd_responder #(
    parameter int CMD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] lcd_data,
    input  logic [1:0] lcd_ctrl,
    input  logic       lcd_enable,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic [6:0] ac,
    output logic       display_on,
    output logic       entry_inc,
    output logic       cmd_strobe,
    output logic [1:0] err,
    input  logic [6:0] dbg_addr,
    output logic [7:0] dbg_char
);
    localparam int CNT_W = $clog2(CMD_CYCLES + 1);

    typedef enum logic [1:0] {S_CLEARING, S_BUSY, S_IDLE} state_t;

    state_t           r_state, w_state_nxt;
    logic [6:0]       r_clr_idx, w_clr_idx_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [6:0]       r_ac, w_ac_nxt;
    logic             r_entry_inc, w_entry_nxt;
    logic             r_display_on, w_disp_nxt;
    logic [1:0]       r_err, w_err_nxt;
    logic             r_strobe, w_strobe_nxt;
    logic [7:0]       r_rd_data, w_rd_nxt;
    logic             r_en_q;
    logic [7:0]       r_data_q;
    logic [1:0]       r_ctrl_q;
    logic [7:0]       r_ddram [80];
    logic             w_we;
    logic [6:0]       w_we_idx;
    logic [7:0]       w_we_byte;
    logic             w_fall, w_rise;

    // Both DDRAM lines share the same offset range 0x00-0x27 in bits [5:0].
    function automatic logic addr_legal(input logic [6:0] a);
        return a[5:0] <= 6'd39;
    endfunction

    function automatic logic [6:0] addr_idx(input logic [6:0] a);
        return a[6] ? (7'(a[5:0]) + 7'd40) : a;
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        if (inc)
            return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
        else
            return (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
    endfunction

    assign w_fall     = r_en_q && !lcd_enable;
    assign w_rise     = !r_en_q && lcd_enable;
    assign busy       = (r_state != S_IDLE);
    assign ac         = r_ac;
    assign display_on = r_display_on;
    assign entry_inc  = r_entry_inc;
    assign cmd_strobe = r_strobe;
    assign err        = r_err;
    assign rd_data    = r_rd_data;
    assign dbg_char   = addr_legal(dbg_addr) ? r_ddram[addr_idx(dbg_addr)] : 8'h00;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state      <= S_CLEARING;
            r_clr_idx    <= 7'd0;
            r_cnt        <= '0;
            r_ac         <= 7'd0;
            r_entry_inc  <= 1'b1;
            r_display_on <= 1'b0;
            r_err        <= 2'b00;
            r_strobe     <= 1'b0;
            r_rd_data    <= 8'h00;
            r_en_q       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_clr_idx    <= w_clr_idx_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ac         <= w_ac_nxt;
            r_entry_inc  <= w_entry_nxt;
            r_display_on <= w_disp_nxt;
            r_err        <= w_err_nxt;
            r_strobe     <= w_strobe_nxt;
            r_rd_data    <= w_rd_nxt;
            r_en_q       <= lcd_enable;
        end
    end

    // Bus data/control captures and the DDRAM carry no reset; the clear sequence fills it.
    always_ff @(posedge clk) begin
        r_data_q <= lcd_data;
        r_ctrl_q <= lcd_ctrl;
        if (w_we)
            r_ddram[w_we_idx] <= w_we_byte;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        w_cnt_nxt     = r_cnt;
        w_ac_nxt      = r_ac;
        w_entry_nxt   = r_entry_inc;
        w_disp_nxt    = r_display_on;
        w_err_nxt     = r_err;
        w_strobe_nxt  = 1'b0;
        w_rd_nxt      = r_rd_data;
        w_we          = 1'b0;
        w_we_idx      = r_clr_idx;
        w_we_byte     = 8'h20;

        case (r_state)
            S_CLEARING: begin
                w_we = 1'b1;
                if (r_clr_idx == 7'd79)
                    w_state_nxt = S_IDLE;
                else
                    w_clr_idx_nxt = r_clr_idx + 7'd1;
            end
            S_BUSY: begin
                if (r_cnt <= CNT_W'(1))
                    w_state_nxt = S_IDLE;
                else
                    w_cnt_nxt = r_cnt - CNT_W'(1);
            end
            default: ;
        endcase

        if (w_rise && lcd_ctrl[1])
            w_rd_nxt = lcd_ctrl[0] ? r_ddram[addr_idx(r_ac)] : {busy, r_ac};
        if (w_fall && r_ctrl_q[1] && r_ctrl_q[0])
            w_ac_nxt = ac_step(r_ac, r_entry_inc);

        // Writes come last so they take priority over a read's ac advance.
        if (w_fall && !r_ctrl_q[1]) begin
            if (r_state != S_IDLE) begin
                w_err_nxt[0] = 1'b1;
            end else begin
                w_strobe_nxt = 1'b1;
                w_state_nxt  = S_BUSY;
                w_cnt_nxt    = CNT_W'(CMD_CYCLES);
                if (r_ctrl_q[0]) begin
                    w_we      = 1'b1;
                    w_we_idx  = addr_idx(r_ac);
                    w_we_byte = r_data_q;
                    w_ac_nxt  = ac_step(r_ac, r_entry_inc);
                end else begin
                    casez (r_data_q)
                        8'b0000_0001: begin
                            w_ac_nxt      = 7'd0;
                            w_entry_nxt   = 1'b1;
                            w_state_nxt   = S_CLEARING;
                            w_clr_idx_nxt = 7'd0;
                        end
                        8'b0000_001?: w_ac_nxt = 7'd0;
                        8'b0000_01??: w_entry_nxt = r_data_q[1];
                        8'b0000_1???: w_disp_nxt = r_data_q[2];
                        8'b001?_????: ;
                        8'b1???_????: begin
                            if (addr_legal(r_data_q[6:0]))
                                w_ac_nxt = r_data_q[6:0];
                            else
                                w_err_nxt[1] = 1'b1;
                        end
                        default: w_err_nxt[1] = 1'b1;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_lcd_responder.sv
// Directed bench for lcd_responder: a transaction-level model tracks the expected
// register/DDRAM state, a per-cycle compare process checks outputs, literals pin key points.
`timescale 1ns/1ps
module tb_lcd_responder;
    localparam int CMD_CYCLES = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] lcd_data;
    logic [1:0] lcd_ctrl;
    logic       lcd_enable;
    logic [7:0] rd_data;
    logic       busy;
    logic [6:0] ac;
    logic       display_on;
    logic       entry_inc;
    logic       cmd_strobe;
    logic [1:0] err;
    logic [6:0] dbg_addr;
    logic [7:0] dbg_char;

    lcd_responder #(.CMD_CYCLES(CMD_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .lcd_data(lcd_data), .lcd_ctrl(lcd_ctrl),
        .lcd_enable(lcd_enable), .rd_data(rd_data), .busy(busy), .ac(ac),
        .display_on(display_on), .entry_inc(entry_inc), .cmd_strobe(cmd_strobe),
        .err(err), .dbg_addr(dbg_addr), .dbg_char(dbg_char)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int n_strobe = 0;
    bit chk_en = 1'b0;

    // Model state; busy_end is the posedge index at which the responder goes idle.
    logic [6:0] m_ac;
    bit         m_entry;
    bit         m_disp;
    logic [1:0] m_err;
    logic [7:0] m_rd;
    int         busy_end;
    int         strobe_cyc;
    logic [7:0] m_ram [80];
    bit         m_ram_valid;

    function automatic int a2i(input logic [6:0] a);
        return (a >= 7'h40) ? int'(a) - 'h40 + 40 : int'(a);
    endfunction

    function automatic logic [6:0] i2a(input int i);
        return (i < 40) ? 7'(i) : 7'(i - 40 + 'h40);
    endfunction

    function automatic bit legal(input logic [6:0] a);
        return (a <= 7'h27) || (a >= 7'h40 && a <= 7'h67);
    endfunction

    function automatic logic [6:0] step(input logic [6:0] a, input bit inc);
        return i2a(inc ? (a2i(a) + 1) % 80 : (a2i(a) + 79) % 80);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ac", 32'(ac), 32'(m_ac));
            chk("busy", 32'(busy), 32'(cyc < busy_end));
            chk("display_on", 32'(display_on), 32'(m_disp));
            chk("entry_inc", 32'(entry_inc), 32'(m_entry));
            chk("err", 32'(err), 32'(m_err));
            chk("cmd_strobe", 32'(cmd_strobe), 32'(cyc == strobe_cyc));
            chk("rd_data", 32'(rd_data), 32'(m_rd));
            if (cmd_strobe === 1'b1) n_strobe++;
        end
    end

    task automatic model_fall(input bit rw, input bit rs, input logic [7:0] b);
        int p;
        p = cyc;
        if (rw) begin
            if (rs) m_ac = step(m_ac, m_entry);
        end else if (p - 1 < busy_end) begin
            m_err[0] = 1'b1;
        end else begin
            strobe_cyc = p;
            busy_end = p + CMD_CYCLES;
            if (rs) begin
                m_ram[a2i(m_ac)] = b;
                m_ac = step(m_ac, m_entry);
            end else if (b == 8'h01) begin
                m_ac = 7'h00; m_entry = 1'b1; busy_end = p + 80; m_ram_valid = 1'b0;
            end else if (b == 8'h02 || b == 8'h03) m_ac = 7'h00;
            else if (b >= 8'h04 && b <= 8'h07) m_entry = b[1];
            else if (b >= 8'h08 && b <= 8'h0F) m_disp = b[2];
            else if (b >= 8'h20 && b <= 8'h3F) ;
            else if (b >= 8'h80) begin
                if (legal(b[6:0])) m_ac = b[6:0];
                else m_err[1] = 1'b1;
            end else m_err[1] = 1'b1;
        end
    endtask

    task automatic xfer(input bit rw, input bit rs, input logic [7:0] b, input int pre);
        repeat (pre) @(negedge clk);
        @(negedge clk);
        lcd_data = b; lcd_ctrl = {rw, rs}; lcd_enable = 1'b1;
        @(posedge clk); #1;
        if (rw) m_rd = rs ? m_ram[a2i(m_ac)] : {(cyc - 1 < busy_end), m_ac};
        @(negedge clk);
        lcd_enable = 1'b0;
        @(posedge clk); #1;
        model_fall(rw, rs, b);
    endtask

    task automatic settle();
        while (cyc < busy_end) @(negedge clk);
        if (!m_ram_valid) begin
            for (int i = 0; i < 80; i++) m_ram[i] = 8'h20;
            m_ram_valid = 1'b1;
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #2;
        rst_n = 1'b1;
        m_ac = 7'h00; m_entry = 1'b1; m_disp = 1'b0; m_err = 2'b00; m_rd = 8'h00;
        busy_end = 32'h3fff_ffff; strobe_cyc = -10; m_ram_valid = 1'b0; chk_en = 1'b1;
        repeat (n) @(negedge clk);
        rst_n = 1'b0;
        busy_end = cyc + 80;
    endtask

    task automatic measure_busy();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len_after_reset", n, 80);
    endtask

    task automatic check_dbg(input logic [6:0] a, input logic [7:0] exp);
        dbg_addr = a;
        #1;
        chk($sformatf("dbg_char@%02h", a), 32'(dbg_char), 32'(exp));
        if (m_ram_valid)
            chk($sformatf("dbg_model@%02h", a), 32'(dbg_char),
                32'(legal(a) ? m_ram[a2i(a)] : 8'h00));
    endtask

    initial begin
        int s0;
        lcd_data = 8'h00; lcd_ctrl = 2'b00; lcd_enable = 1'b0; dbg_addr = 7'h00;

        do_reset(3);
        measure_busy();
        settle();
        check_dbg(7'h00, 8'h20); check_dbg(7'h27, 8'h20);
        check_dbg(7'h40, 8'h20); check_dbg(7'h67, 8'h20);
        check_dbg(7'h28, 8'h00);
        chk("ac_after_reset", 32'(ac), 32'h0);

        xfer(0, 0, 8'hA6, 0); settle();
        s0 = n_strobe;
        xfer(0, 1, 8'h41, 0); settle();
        xfer(0, 1, 8'h42, 0); settle();
        xfer(0, 1, 8'h43, 0); settle();
        check_dbg(7'h26, 8'h41); check_dbg(7'h27, 8'h42); check_dbg(7'h40, 8'h43);
        chk("ac_after_ABC", 32'(ac), 32'h41);
        chk("strobes_ABC", n_strobe - s0, 3);

        xfer(0, 0, 8'h04, 0); settle();
        chk("entry_dec", 32'(entry_inc), 32'h0);
        xfer(0, 0, 8'h80, 0); settle();
        xfer(0, 1, 8'h5A, 0); settle();
        check_dbg(7'h00, 8'h5A);
        chk("ac_dec_wrap", 32'(ac), 32'h67);

        xfer(0, 0, 8'h06, 0); settle();
        xfer(0, 0, 8'h0C, 0); settle();
        chk("display_on_set", 32'(display_on), 32'h1);
        xfer(0, 0, 8'h81, 0); settle();
        xfer(0, 1, 8'h31, 0);
        xfer(0, 1, 8'h32, 0);
        chk("err_busy_write", 32'(err), 32'h1);
        chk("ac_after_reject", 32'(ac), 32'h02);
        check_dbg(7'h02, 8'h20);
        settle();
        xfer(0, 0, 8'hA8, 0);
        chk("err_illegal_addr", 32'(err), 32'h3);
        chk("ac_after_illegal", 32'(ac), 32'h02);
        settle();
        xfer(0, 1, 8'h33, 0);
        xfer(0, 1, 8'h34, 2);
        chk("ac_boundary_reject", 32'(ac), 32'h03);
        check_dbg(7'h03, 8'h20);
        settle();
        xfer(0, 1, 8'h36, 0);
        xfer(0, 1, 8'h37, 3);
        chk("ac_boundary_accept", 32'(ac), 32'h05);
        check_dbg(7'h03, 8'h36); check_dbg(7'h04, 8'h37);

        settle();
        xfer(0, 0, 8'h85, 0); settle();
        xfer(0, 1, 8'h51, 0);
        xfer(1, 0, 8'h00, 0);
        chk("status_read", 32'(rd_data), 32'h86);
        settle();
        xfer(0, 0, 8'h85, 0); settle();
        xfer(1, 1, 8'h00, 0);
        chk("data_read", 32'(rd_data), 32'h51);
        chk("ac_after_read", 32'(ac), 32'h06);

        settle();
        xfer(0, 0, 8'h01, 0);
        repeat (29) @(negedge clk);
        do_reset(2);
        measure_busy();
        settle();
        for (int i = 0; i < 80; i++) check_dbg(i2a(i), 8'h20);
        chk("ac_final", 32'(ac), 32'h0);
        chk("entry_final", 32'(entry_inc), 32'h1);
        chk("display_final", 32'(display_on), 32'h0);
        chk("err_final", 32'(err), 32'h0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
